// File: rtl/led_pattern_scheduler_pkg.sv
// Shared definitions for the LED pattern scheduler: mode encodings, bank width
// and the per-mode LED/chase helpers.
package led_pattern_scheduler_pkg;

    localparam int unsigned LED_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_FLASH = 2'd1,
        MODE_RUN   = 2'd2,
        MODE_MIX   = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_FLASH: next_mode = MODE_RUN;
            MODE_RUN:   next_mode = MODE_MIX;
            default:    next_mode = MODE_FLASH;
        endcase
    endfunction

    // RUN rotates across all four LEDs; MIX rotates only the low three.
    function automatic logic [LED_W-1:0] chase_step(input mode_t m, input logic [LED_W-1:0] c);
        if (m == MODE_MIX)
            chase_step = {1'b0, c[LED_W-3:0], c[LED_W-2]};
        else
            chase_step = {c[LED_W-2:0], c[LED_W-1]};
    endfunction

    function automatic logic [LED_W-1:0] led_value(input mode_t m, input logic fb,
                                                  input logic [LED_W-1:0] c);
        case (m)
            MODE_FLASH: led_value = {LED_W{fb}};
            MODE_RUN:   led_value = c;
            MODE_MIX:   led_value = {fb, c[LED_W-2:0]};
            default:    led_value = '0;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_scheduler_if.sv
// Control/status bundle between button conditioning and the LED scheduler.
interface led_pattern_scheduler_if;
    import led_pattern_scheduler_pkg::*;

    logic             Start;
    logic             Stop;
    logic             Next;
    logic             Hold;
    logic [LED_W-1:0] LED_Out;
    logic [1:0]       Mode;
    logic             Busy;

    modport master (output Start, Stop, Next, Hold, input LED_Out, Mode, Busy);
    modport slave  (input Start, Stop, Next, Hold, output LED_Out, Mode, Busy);

endinterface

// File: rtl/led_tick_gen.sv
// Base-tick prescaler: counts 0..TICK_DIV-1, ticks on the terminal count,
// freezes while hold is high and restarts from zero on clear.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          last;

    assign last = (cnt_q == CW'(TICK_DIV - 1));
    assign tick = !hold && last;

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt_q <= '0;
        else if (!hold)
            cnt_q <= last ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Time-shares the 4-LED bank between FLASH, RUN and MIX patterns with fixed
// dwell, plus start/stop/skip/hold controls. All outputs registered.
module led_pattern_scheduler
    import led_pattern_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 2500000,
    parameter int unsigned FLASH_TICKS = 10,
    parameter int unsigned RUN_TICKS   = 4,
    parameter int unsigned DWELL_TICKS = 100
) (
    input  logic                    CLK,
    input  logic                    RST,
    led_pattern_scheduler_if.slave  bus
);

    localparam int unsigned FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam int unsigned RW = (RUN_TICKS   > 1) ? $clog2(RUN_TICKS)   : 1;
    localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    mode_t            mode_q, mode_d;
    logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
    logic [RW-1:0]    run_cnt_q, run_cnt_d;
    logic [DW-1:0]    dwell_cnt_q, dwell_cnt_d;
    logic             flash_bit_q, flash_bit_d;
    logic [LED_W-1:0] chase_q, chase_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             busy_q, busy_d;
    logic             tick, clear, dwell_done;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (CLK),
        .rst   (RST),
        .clear (clear),
        .hold  (bus.Hold || (mode_q == MODE_OFF)),
        .tick  (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q      <= MODE_OFF;
            flash_cnt_q <= '0;
            run_cnt_q   <= '0;
            dwell_cnt_q <= '0;
            flash_bit_q <= 1'b0;
            chase_q     <= '0;
            led_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            flash_cnt_q <= flash_cnt_d;
            run_cnt_q   <= run_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            flash_bit_q <= flash_bit_d;
            chase_q     <= chase_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        flash_cnt_d = flash_cnt_q;
        run_cnt_d   = run_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        flash_bit_d = flash_bit_q;
        chase_d     = chase_q;
        clear       = 1'b0;
        dwell_done  = tick && (dwell_cnt_q == DW'(DWELL_TICKS - 1));

        if (bus.Stop) begin
            mode_d = MODE_OFF;
            clear  = 1'b1;
        end else if (bus.Start && (mode_q == MODE_OFF)) begin
            mode_d = MODE_FLASH;
            clear  = 1'b1;
        end else if ((mode_q != MODE_OFF) && (bus.Next || dwell_done)) begin
            mode_d = next_mode(mode_q);
            clear  = 1'b1;
        end else if (tick) begin
            if (flash_cnt_q == FW'(FLASH_TICKS - 1)) begin
                flash_cnt_d = '0;
                flash_bit_d = ~flash_bit_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
            if (run_cnt_q == RW'(RUN_TICKS - 1)) begin
                run_cnt_d = '0;
                chase_d   = chase_step(mode_q, chase_q);
            end else begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
            dwell_cnt_d = dwell_cnt_q + 1'b1;
        end

        // Entering OFF restores the reset image; entering a pattern primes it.
        if (clear) begin
            flash_cnt_d = '0;
            run_cnt_d   = '0;
            dwell_cnt_d = '0;
            flash_bit_d = (mode_d != MODE_OFF);
            chase_d     = (mode_d != MODE_OFF) ? LED_W'(1) : '0;
        end

        led_d  = led_value(mode_d, flash_bit_d, chase_d);
        busy_d = (mode_d != MODE_OFF);
    end

    assign bus.LED_Out = led_q;
    assign bus.Mode    = mode_q;
    assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with small timing parameters.
module tb_led_pattern_scheduler;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    led_pattern_scheduler_if bus ();

    led_pattern_scheduler #(
        .TICK_DIV    (2),
        .FLASH_TICKS (2),
        .RUN_TICKS   (1),
        .DWELL_TICKS (6)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] led, input logic [1:0] mode);
        chk({tag, " led"},  {4'b0, bus.LED_Out}, {4'b0, led});
        chk({tag, " mode"}, {6'b0, bus.Mode},    {6'b0, mode});
        chk({tag, " busy"}, {7'b0, bus.Busy},    {7'b0, (mode != 2'd0)});
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.Start = 1'b0; bus.Stop = 1'b0; bus.Next = 1'b0; bus.Hold = 1'b0;
        cyc(2);
        RST = 1'b0;
    endtask

    // Leaves the bench 1 ns after edge e0, which sampled Start high.
    task automatic start_e0();
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
    endtask

    logic [3:0] run_exp [5];

    initial begin
        run_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // 1: reset and idle, Next/Hold have no effect in OFF
        do_reset();
        chk_out("reset", 4'b0000, 2'd0);
        for (int i = 0; i < 50; i++) begin
            bus.Next = (i % 7 == 3);
            bus.Hold = (i % 5 < 2);
            cyc();
            chk_out("idle", 4'b0000, 2'd0);
        end
        bus.Next = 1'b0;
        bus.Hold = 1'b0;

        // 2/3: FLASH -> RUN -> MIX with auto advance; Start at e0+1 is ignored
        start_e0();
        chk_out("e0 flash", 4'b1111, 2'd1);
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        chk_out("e0+1 start ignored", 4'b1111, 2'd1);
        cyc(2);
        chk_out("e0+3", 4'b1111, 2'd1);
        cyc();
        chk_out("e0+4 toggle", 4'b0000, 2'd1);
        cyc(4);
        chk_out("e0+8 toggle", 4'b1111, 2'd1);
        cyc(3);
        chk_out("e0+11 pre-dwell", 4'b1111, 2'd1);
        cyc();
        chk_out("e0+12 run", 4'b0001, 2'd2);
        for (int i = 0; i < 5; i++) begin
            cyc(2);
            chk_out("run step", run_exp[i], 2'd2);
        end
        cyc();
        chk_out("e0+23", 4'b0010, 2'd2);
        cyc();
        chk_out("e0+24 mix", 4'b1001, 2'd3);
        cyc(2);
        chk_out("mix step", 4'b1010, 2'd3);
        cyc(2);
        chk_out("mix toggle", 4'b0100, 2'd3);

        // 4: Next skip, and Next coinciding with dwell expiry
        do_reset();
        start_e0();
        cyc(4);
        chk_out("n e0+4", 4'b0000, 2'd1);
        bus.Next = 1'b1;
        cyc();
        bus.Next = 1'b0;
        chk_out("n e0+5 skip", 4'b0001, 2'd2);
        cyc();
        chk_out("n e0+6", 4'b0001, 2'd2);
        cyc();
        chk_out("n e0+7 step", 4'b0010, 2'd2);
        cyc(9);
        chk_out("n e0+16", 4'b0010, 2'd2);
        bus.Next = 1'b1;
        cyc();
        bus.Next = 1'b0;
        chk_out("n e0+17 single adv", 4'b1001, 2'd3);
        cyc();
        chk_out("n e0+18", 4'b1001, 2'd3);
        cyc();
        chk_out("n e0+19", 4'b1010, 2'd3);

        // 5: Hold freezes timing; then Stop+Start together in RUN
        do_reset();
        start_e0();
        cyc(2);
        bus.Hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_out("hold", 4'b1111, 2'd1);
        end
        bus.Hold = 1'b0;
        cyc();
        chk_out("h e0+23", 4'b1111, 2'd1);
        cyc();
        chk_out("h e0+24 toggle", 4'b0000, 2'd1);
        cyc(7);
        chk_out("h e0+31", 4'b1111, 2'd1);
        cyc();
        chk_out("h e0+32 dwell", 4'b0001, 2'd2);
        cyc();
        bus.Stop = 1'b1;
        bus.Start = 1'b1;
        cyc();
        bus.Stop = 1'b0;
        bus.Start = 1'b0;
        chk_out("stop+start", 4'b0000, 2'd0);
        cyc(3);
        chk_out("stopped", 4'b0000, 2'd0);

        // 6: RST in MIX, then RST together with Start
        do_reset();
        start_e0();
        cyc(24);
        chk_out("r mix", 4'b1001, 2'd3);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk_out("rst in mix", 4'b0000, 2'd0);
        RST = 1'b1;
        bus.Start = 1'b1;
        cyc();
        RST = 1'b0;
        bus.Start = 1'b0;
        chk_out("rst+start", 4'b0000, 2'd0);
        cyc(2);
        chk_out("rst+start later", 4'b0000, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
